// File: rtl/eth_tx_arb.sv
// Packet-granular round-robin arbiter that shares the 10G MAC transmit AXI-Stream
// between NUM_REQ requesters, with an oversize-packet abort/drain path and tx_enable gating.
module eth_tx_arb #(
   parameter  int unsigned NUM_REQ    = 2,
   parameter  int unsigned DATA_WIDTH = 64,
   parameter  int unsigned MAX_BEATS  = 1200,
   localparam int unsigned GW         = $clog2(NUM_REQ),
   localparam int unsigned KW         = DATA_WIDTH / 8
) (
   input  logic                          clk156,
   input  logic                          eth_rst,
   input  logic                          tx_enable,
   input  logic [NUM_REQ-1:0]            s_axis_tvalid,
   output logic [NUM_REQ-1:0]            s_axis_tready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_REQ*KW-1:0]         s_axis_tkeep,
   input  logic [NUM_REQ-1:0]            s_axis_tlast,
   input  logic [NUM_REQ-1:0]            s_axis_tuser,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [KW-1:0]                 m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy,
   output logic [31:0]                   tx_pkt_cnt,
   output logic [15:0]                   abort_cnt
);

   localparam int unsigned BW = $clog2(MAX_BEATS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   pick;
   logic            found;
   logic [BW-1:0]   beat_cnt;
   logic            at_limit;
   logic            xfer;

   logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
   logic [KW-1:0]         req_keep [NUM_REQ];
   logic                  src_valid;
   logic                  src_last;
   logic                  src_user;
   logic [DATA_WIDTH-1:0] src_data;
   logic [KW-1:0]         src_keep;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      assign req_keep[i] = s_axis_tkeep[i*KW +: KW];
   end

   assign src_valid = s_axis_tvalid[grant_id];
   assign src_last  = s_axis_tlast[grant_id];
   assign src_user  = s_axis_tuser[grant_id];
   assign src_data  = req_data[grant_id];
   assign src_keep  = req_keep[grant_id];

   assign at_limit  = (beat_cnt == BW'(MAX_BEATS - 1));
   assign xfer      = m_axis_tvalid & m_axis_tready;
   assign busy      = (state != IDLE);

   // Round-robin search starting just after the last completed grant.
   always_comb begin
      pick  = last_grant;
      found = 1'b0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!found && s_axis_tvalid[GW'((32'(last_grant) + k) % NUM_REQ)]) begin
            found = 1'b1;
            pick  = GW'((32'(last_grant) + k) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clk156 or posedge eth_rst) begin
      if (eth_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state plus the combinational stream mux from the registered grant.
   always_comb begin
      state_nxt     = state;
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = src_data;
      m_axis_tkeep  = src_keep;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      case (state)
         IDLE: begin
            if (tx_enable && found) state_nxt = BUSY;
         end
         BUSY: begin
            m_axis_tvalid           = src_valid;
            m_axis_tlast            = src_last | at_limit;
            m_axis_tuser            = src_user | (at_limit & ~src_last);
            s_axis_tready[grant_id] = m_axis_tready;
            if (src_valid && m_axis_tready) begin
               if (src_last)      state_nxt = IDLE;
               else if (at_limit) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            s_axis_tready[grant_id] = 1'b1;
            if (src_valid && src_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grant, beat counter and statistics.
   always_ff @(posedge clk156 or posedge eth_rst) begin
      if (eth_rst) begin
         grant_id   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
         beat_cnt   <= '0;
         tx_pkt_cnt <= '0;
         abort_cnt  <= '0;
      end else begin
         if (state == IDLE && state_nxt == BUSY) begin
            grant_id <= pick;
            beat_cnt <= '0;
         end
         if (state == BUSY && xfer) begin
            beat_cnt <= beat_cnt + BW'(1);
            if (src_last) begin
               tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
               last_grant <= grant_id;
            end else if (at_limit && abort_cnt != 16'hFFFF) begin
               abort_cnt <= abort_cnt + 16'd1;
            end
         end
         if (state == DRAIN && src_valid && src_last) last_grant <= grant_id;
      end
   end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb: per-requester source queues feed the DUT,
// expected MAC beats are queued at issue time and checked by an independent monitor.
module tb_eth_tx_arb;

   localparam int unsigned NR   = 2;
   localparam int unsigned DW   = 64;
   localparam int unsigned KW   = 8;
   localparam int unsigned MAXB = 4;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
      logic        gid;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            tx_enable;
   logic [NR-1:0]   s_tvalid;
   logic [NR-1:0]   s_tready;
   logic [NR*DW-1:0] s_tdata;
   logic [NR*KW-1:0] s_tkeep;
   logic [NR-1:0]   s_tlast;
   logic [NR-1:0]   s_tuser;
   logic            m_tvalid;
   logic            m_tready;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tlast;
   logic            m_tuser;
   logic            grant_id;
   logic            busy;
   logic [31:0]     tx_pkt_cnt;
   logic [15:0]     abort_cnt;

   beat_t q0[$];
   beat_t q1[$];
   exp_t  exp_q[$];
   int    n_chk   = 0;
   int    n_fail  = 0;
   int    pkt_id  = 0;
   bit    gap_chk = 0;

   eth_tx_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(MAXB)) dut (
      .clk156        (clk),
      .eth_rst       (rst),
      .tx_enable     (tx_enable),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tlast  (s_tlast),
      .s_axis_tuser  (s_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
      .grant_id      (grant_id),
      .busy          (busy),
      .tx_pkt_cnt    (tx_pkt_cnt),
      .abort_cnt     (abort_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Source beats go to the requester queue; the MAC-side expectation is derived here.
   task automatic queue_pkt(input int r, input int n, input bit usr);
      for (int b = 0; b < n; b++) begin
         beat_t s;
         exp_t  e;
         s.data = {8'hA5, 8'(r), 16'(pkt_id), 16'(b), 16'hC0DE};
         s.keep = (b == n - 1) ? 8'h0F : 8'hFF;
         s.last = (b == n - 1);
         s.user = usr && (b == n - 1);
         if (r == 0) q0.push_back(s);
         else        q1.push_back(s);
         if (b < int'(MAXB)) begin
            e.data = s.data;
            e.keep = s.keep;
            e.last = s.last || (b == int'(MAXB) - 1);
            e.user = s.user || ((b == int'(MAXB) - 1) && !s.last);
            e.gid  = (r != 0);
            exp_q.push_back(e);
         end
      end
      pkt_id++;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   // Requester model: handshakes sampled at negedge, next beat presented after the edge.
   initial begin
      logic [NR-1:0] hs;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      s_tuser  = '0;
      forever begin
         @(negedge clk);
         hs = s_tvalid & s_tready;
         @(posedge clk);
         #1;
         if (hs[0] && q0.size() > 0) void'(q0.pop_front());
         if (hs[1] && q1.size() > 0) void'(q1.pop_front());
         if (q0.size() > 0) begin
            s_tvalid[0] = 1'b1; s_tdata[63:0] = q0[0].data; s_tkeep[7:0] = q0[0].keep;
            s_tlast[0]  = q0[0].last; s_tuser[0] = q0[0].user;
         end else s_tvalid[0] = 1'b0;
         if (q1.size() > 0) begin
            s_tvalid[1] = 1'b1; s_tdata[127:64] = q1[0].data; s_tkeep[15:8] = q1[0].keep;
            s_tlast[1]  = q1[0].last; s_tuser[1] = q1[0].user;
         end else s_tvalid[1] = 1'b0;
      end
   end

   // Monitor: every MAC handshake must match the head of the expected queue.
   initial begin
      int   cyc      = 0;
      int   last_cyc = 0;
      bit   prev_last = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) prev_last = 0;
         else if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_beat: got data 0x%0h, expected no beat at %0t", m_tdata, $time);
            end else begin
               e = exp_q.pop_front();
               check("tdata", m_tdata, e.data);
               check("tkeep", 64'(m_tkeep), 64'(e.keep));
               check("tlast", 64'(m_tlast), 64'(e.last));
               check("tuser", 64'(m_tuser), 64'(e.user));
               check("grant", 64'(grant_id), 64'(e.gid));
               if (gap_chk && prev_last) check("bubble_cycles", 64'(cyc - last_cyc), 64'd2);
            end
            prev_last = m_tlast;
            last_cyc  = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      rst       = 1'b1;
      tx_enable = 1'b1;
      m_tready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",      64'(busy),       64'd0);
      check("rst_grant",     64'(grant_id),   64'd0);
      check("rst_m_tvalid",  64'(m_tvalid),   64'd0);
      check("rst_m_tlast",   64'(m_tlast),    64'd0);
      check("rst_m_tuser",   64'(m_tuser),    64'd0);
      check("rst_s_tready",  64'(s_tready),   64'd0);
      check("rst_tx_pkt",    64'(tx_pkt_cnt), 64'd0);
      check("rst_abort",     64'(abort_cnt),  64'd0);
      rst = 1'b0;

      // Single requester, 3 beats, one-cycle grant latency
      @(negedge clk);
      queue_pkt(0, 3, 0);
      @(negedge clk);
      check("t1_bubble_tvalid", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      check("t1_first_tvalid",  64'(m_tvalid), 64'd1);
      wait_done("t1_done", 30);
      check("t1_tx_pkt", 64'(tx_pkt_cnt), 64'd1);
      check("t1_grant",  64'(grant_id),   64'd0);

      // Two continuous requesters alternate 0,1,0,1 with one bubble each
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      gap_chk = 1;
      queue_pkt(0, 4, 0);
      queue_pkt(1, 4, 0);
      queue_pkt(0, 4, 0);
      queue_pkt(1, 4, 1);
      wait_done("t2_done", 60);
      gap_chk = 0;
      check("t2_tx_pkt", 64'(tx_pkt_cnt), 64'd4);
      check("t2_grant",  64'(grant_id),   64'd1);

      // Oversize abort then drain; exact-limit packet is normal
      queue_pkt(1, 6, 0);
      wait_done("t3_abort_done", 40);
      check("t3_abort_cnt", 64'(abort_cnt),  64'd1);
      check("t3_tx_pkt",    64'(tx_pkt_cnt), 64'd4);
      queue_pkt(1, 4, 0);
      wait_done("t3_exact_done", 40);
      check("t3_exact_abort", 64'(abort_cnt),  64'd1);
      check("t3_exact_tx",    64'(tx_pkt_cnt), 64'd5);

      // Back-pressure toggling 1,0,1,0
      @(negedge clk);
      queue_pkt(0, 4, 0);
      n = 0;
      while ((exp_q.size() != 0 || q0.size() != 0) && n < 40) begin
         @(negedge clk);
         if (m_tvalid) begin
            check("t4_s_tready0", 64'(s_tready[0]), 64'(m_tready));
            check("t4_s_tready1", 64'(s_tready[1]), 64'd0);
         end
         @(posedge clk);
         #2 m_tready = ~m_tready;
         n++;
      end
      m_tready = 1'b1;
      wait_done("t4_done", 20);
      check("t4_tx_pkt", 64'(tx_pkt_cnt), 64'd6);

      // tx_enable gating
      @(negedge clk);
      tx_enable = 1'b0;
      queue_pkt(0, 4, 0);
      queue_pkt(0, 4, 0);
      repeat (5) @(negedge clk);
      check("t5_idle_busy",   64'(busy),     64'd0);
      check("t5_idle_tvalid", 64'(m_tvalid), 64'd0);
      check("t5_idle_tready", 64'(s_tready), 64'd0);
      tx_enable = 1'b1;
      n = 0;
      while (!busy && n < 20) begin @(negedge clk); n++; end
      check("t5_granted", 64'(busy), 64'd1);
      tx_enable = 1'b0;
      n = 0;
      while (!(q0.size() == 4 && exp_q.size() == 4) && n < 30) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      check("t5_held_busy",  64'(busy),       64'd0);
      check("t5_held_queue", 64'(q0.size()),  64'd4);
      check("t5_held_tx",    64'(tx_pkt_cnt), 64'd7);
      tx_enable = 1'b1;
      wait_done("t5_done", 30);
      check("t5_tx_pkt", 64'(tx_pkt_cnt), 64'd8);

      // Asynchronous reset during beat 2
      @(negedge clk);
      queue_pkt(0, 4, 0);
      n = 0;
      while (exp_q.size() != 3 && n < 30) begin @(posedge clk); n++; end
      #3 rst = 1'b1;
      #1;
      check("t6_busy",     64'(busy),       64'd0);
      check("t6_m_tvalid", 64'(m_tvalid),   64'd0);
      check("t6_m_tlast",  64'(m_tlast),    64'd0);
      check("t6_s_tready", 64'(s_tready),   64'd0);
      check("t6_grant",    64'(grant_id),   64'd0);
      check("t6_tx_pkt",   64'(tx_pkt_cnt), 64'd0);
      check("t6_abort",    64'(abort_cnt),  64'd0);
      q0.delete();
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t6_post_tx",    64'(tx_pkt_cnt), 64'd0);
      check("t6_post_abort", 64'(abort_cnt),  64'd0);
      queue_pkt(0, 2, 0);
      queue_pkt(1, 2, 0);
      wait_done("t6_done", 30);
      check("t6_final_tx", 64'(tx_pkt_cnt), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
